// File: rtl/soft_rst_pkg.sv
// rtl/soft_rst_pkg.sv - shared types and constants for the soft-reset sequencer
package soft_rst_pkg;

  localparam int NUM_DOM   = 3;
  localparam int DOM_SDRAM = 0;
  localparam int DOM_SYS   = 1;
  localparam int DOM_SYS2X = 2;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    HOLD,
    RELEASE,
    DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-stage level synchronizer for one acknowledge bit
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic pclk,
  input  logic prst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/soft_reset_ctrl.sv
// rtl/soft_reset_ctrl.sv - software soft-reset sequencer for SDRAM, sys and sys_2x domains
module soft_reset_ctrl
  import soft_rst_pkg::*;
#(
  parameter int STRETCH_CYCLES = 16,
  parameter int ACK_TIMEOUT    = 255,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               pclk,
  input  logic               prst_n,
  input  logic               test_mode,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] sw_rst_sel,
  input  logic [NUM_DOM-1:0] rst_ack,
  input  logic               err_clr,
  output logic [NUM_DOM-1:0] soft_rst_n,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(STRETCH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DOM-1:0] sel_q, sel_d;
  logic               req_q, req_d;
  logic [NUM_DOM-1:0] srn_q, srn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               err_set;
  logic [NUM_DOM-1:0] ack_s;

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .pclk   (pclk),
      .prst_n (prst_n),
      .d      (rst_ack[i]),
      .q      (ack_s[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    req_d   = req_q;
    srn_d   = srn_q;
    err_set = 1'b0;

    // Requests are captured one edge before the FSM acts, and only when idle.
    if (state_q == IDLE && !req_q && sw_rst_req && !test_mode) begin
      req_d = 1'b1;
      sel_d = sw_rst_sel;
    end

    case (state_q)
      IDLE: begin
        if (req_q) begin
          req_d = 1'b0;
          if (!test_mode) begin
            if (sel_q != '0) begin
              state_d = ASSERT;
              cnt_d   = '0;
              srn_d   = ~sel_q;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      ASSERT: begin
        cnt_d = sat_inc(cnt_q);
        if ((ack_s & sel_q) == sel_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          err_set = 1'b1;
          srn_d   = '1;
          state_d = DONE;
        end
      end
      HOLD: begin
        cnt_d = sat_inc(cnt_q);
        if (cnt_q == HOLD_LAST) begin
          srn_d   = '1;
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        cnt_d = sat_inc(cnt_q);
        if ((ack_s & sel_q) == '0) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_set = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        srn_d   = '1;
      end
    endcase

    // Scan/test entry abandons any sequence silently.
    if (test_mode && state_q != IDLE) begin
      state_d = IDLE;
      srn_d   = '1;
      cnt_d   = '0;
      err_set = 1'b0;
    end

    err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      req_q   <= 1'b0;
      srn_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      srn_q   <= srn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign soft_rst_n  = test_mode ? '1 : srn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_soft_reset_ctrl.sv
// tb/tb_soft_reset_ctrl.sv - directed scoreboard bench for soft_reset_ctrl
module tb_soft_reset_ctrl;

  localparam int STRETCH = 16;
  localparam int ACK_TO  = 255;
  localparam int SYNC    = 2;
  localparam int ACK_DLY = 3;
  localparam int NOM_LOW = ACK_DLY + SYNC + 1 + STRETCH;

  logic       pclk = 1'b0;
  logic       prst_n = 1'b0;
  logic       test_mode = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] sw_rst_sel = 3'b000;
  logic [2:0] rst_ack;
  logic       err_clr = 1'b0;
  logic [2:0] soft_rst_n;
  logic       busy;
  logic       done;
  logic       timeout_err;

  soft_reset_ctrl #(
    .STRETCH_CYCLES (STRETCH),
    .ACK_TIMEOUT    (ACK_TO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .pclk        (pclk),
    .prst_n      (prst_n),
    .test_mode   (test_mode),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_sel  (sw_rst_sel),
    .rst_ack     (rst_ack),
    .err_clr     (err_clr),
    .soft_rst_n  (soft_rst_n),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 pclk = ~pclk;

  // Domain model: ack echoes inverted soft reset three cycles later, or sticks.
  logic [2:0] d0 = 3'b000, d1 = 3'b000, d2 = 3'b000;
  int         ack_mode = 0;
  always @(posedge pclk) begin
    d0 <= ~soft_rst_n;
    d1 <= d0;
    d2 <= d1;
  end
  assign rst_ack = (ack_mode == 0) ? d2 : ((ack_mode == 1) ? 3'b000 : 3'b111);

  int         low_cnt = 0;
  int         done_cnt = 0;
  int         unsel_cnt = 0;
  logic [2:0] sel_cur = 3'b000;
  always @(posedge pclk) begin
    #2;
    if (soft_rst_n !== 3'b111) low_cnt++;
    if (done === 1'b1) done_cnt++;
    if ((~soft_rst_n & ~sel_cur) !== 3'b000) unsel_cnt++;
  end

  typedef struct {
    string tag;
    int    low;
    int    dones;
    logic  err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   base_low, base_done, base_unsel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives a request before edge 0 and returns just after edge 1.
  task automatic request(input logic [2:0] sel, input string tag, input int low,
                         input int dn, input logic err);
    exp_t e;
    @(negedge pclk);
    base_low   = low_cnt;
    base_done  = done_cnt;
    base_unsel = unsel_cnt;
    sel_cur    = sel;
    sw_rst_sel = sel;
    sw_rst_req = 1'b1;
    e.tag = tag; e.low = low; e.dones = dn; e.err = err;
    sb.push_back(e);
    @(negedge pclk);
    sw_rst_req = 1'b0;
    @(negedge pclk);
  endtask

  task automatic finish_seq(input bit wait_done, input int budget);
    exp_t e;
    int   n;
    n = 0;
    if (wait_done) begin
      while (done !== 1'b1 && n < budget) begin
        @(negedge pclk);
        n++;
      end
      chk("done_within_budget", {31'd0, done}, 32'd1);
    end
    repeat (3) @(negedge pclk);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_low_cycles"}, low_cnt - base_low, e.low);
      chk({e.tag, "_done_pulses"}, done_cnt - base_done, e.dones);
      chk({e.tag, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, e.err});
      chk({e.tag, "_unsel_low"}, unsel_cnt - base_unsel, 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_soft_rst_n"}, {29'd0, soft_rst_n}, 32'd7);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge pclk);
    check_reset_vals("reset");
    prst_n = 1'b1;
    repeat (4) @(negedge pclk);

    // Nominal two-domain sequence
    request(3'b011, "nominal", NOM_LOW, 1, 1'b0);
    chk("nominal_busy_edge1", {31'd0, busy}, 32'd1);
    chk("nominal_srn_edge1", {29'd0, soft_rst_n}, 32'd4);
    finish_seq(1'b1, 600);

    // ASSERT timeout with sys_2x ack stuck low
    repeat (8) @(negedge pclk);
    ack_mode = 1;
    request(3'b100, "assert_to", ACK_TO, 1, 1'b1);
    chk("assert_to_srn_edge1", {29'd0, soft_rst_n}, 32'd3);
    finish_seq(1'b1, 600);
    chk("assert_to_srn_after", {29'd0, soft_rst_n}, 32'd7);
    @(negedge pclk);
    err_clr = 1'b1;
    @(negedge pclk);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, timeout_err}, 32'd0);
    ack_mode = 0;

    // Second request mid-HOLD is dropped
    repeat (8) @(negedge pclk);
    request(3'b001, "busy_req", NOM_LOW, 1, 1'b0);
    repeat (12) @(negedge pclk);
    sw_rst_sel = 3'b010;
    sw_rst_req = 1'b1;
    @(negedge pclk);
    sw_rst_req = 1'b0;
    finish_seq(1'b1, 600);
    repeat (5) @(negedge pclk);
    chk("busy_req_idle_after", {31'd0, busy}, 32'd0);

    // Zero-select request
    request(3'b000, "zero_sel", 0, 1, 1'b0);
    chk("zero_done_edge1", {31'd0, done}, 32'd1);
    chk("zero_busy_edge1", {31'd0, busy}, 32'd1);
    chk("zero_srn_edge1", {29'd0, soft_rst_n}, 32'd7);
    @(negedge pclk);
    chk("zero_busy_edge2", {31'd0, busy}, 32'd0);
    chk("zero_done_edge2", {31'd0, done}, 32'd0);
    finish_seq(1'b0, 0);

    // test_mode abort during HOLD
    repeat (8) @(negedge pclk);
    request(3'b011, "tmode", 10, 0, 1'b0);
    repeat (9) @(negedge pclk);
    test_mode = 1'b1;
    #1;
    chk("tmode_srn_comb", {29'd0, soft_rst_n}, 32'd7);
    @(negedge pclk);
    chk("tmode_busy_next", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge pclk);
    test_mode = 1'b0;
    finish_seq(1'b0, 0);

    // Asynchronous reset during ASSERT, then a normal sequence
    repeat (8) @(negedge pclk);
    request(3'b011, "arst", 2, 0, 1'b0);
    @(negedge pclk);
    #1;
    prst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    finish_seq(1'b0, 0);
    prst_n = 1'b1;
    repeat (8) @(negedge pclk);
    request(3'b011, "post_arst", NOM_LOW, 1, 1'b0);
    finish_seq(1'b1, 600);

    // RELEASE timeout with acks stuck high
    repeat (8) @(negedge pclk);
    request(3'b001, "release_to", NOM_LOW, 1, 1'b1);
    repeat (9) @(negedge pclk);
    ack_mode = 2;
    finish_seq(1'b1, 700);
    chk("release_to_srn_after", {29'd0, soft_rst_n}, 32'd7);
    @(negedge pclk);
    err_clr = 1'b1;
    @(negedge pclk);
    err_clr = 1'b0;
    chk("release_err_clr", {31'd0, timeout_err}, 32'd0);
    ack_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soft_reset_ctrl.md
# soft_reset_ctrl

Software-requested soft-reset sequencer in the PCI clock domain. Runs downstream of the power-on reset synchronizers and gates the SDRAM, sys and sys_2x domains. On a register-write request it asserts active-low soft resets to the selected domains, waits for each domain to acknowledge through synchronized handshake levels, holds for a stretch period, then releases and confirms release. Domain-side logic ANDs soft_rst_n[i] with its own synchronized power-on reset.

## Interface
- STRETCH_CYCLES, 16: pclk cycles reset is held after all selected acks are seen; legal range 1..255.
- ACK_TIMEOUT, 255: maximum pclk cycles spent waiting in ASSERT or RELEASE; legal range 1..255.
- SYNC_STAGES, 2: flop stages in each ack synchronizer; minimum 2.
- pclk  in  1  PCI clock; all logic is in this domain.
- prst_n  in  1  asynchronous, active-low reset.
- test_mode  in  1  scan/test; forces all soft resets inactive.
- sw_rst_req  in  1  single-cycle request strobe from register write.
- sw_rst_sel  in  3  domain select, sampled with sw_rst_req: bit0 SDRAM, bit1 sys, bit2 sys_2x.
- rst_ack  in  3  per-domain asynchronous level; high while the domain is held in soft reset.
- err_clr  in  1  clears timeout_err.
- soft_rst_n  out  3  per-domain soft reset, active low, registered.
- busy  out  1  high while the FSM is not IDLE.
- done  out  1  one-cycle pulse when a sequence completes.
- timeout_err  out  1  sticky flag for an ack-wait timeout.

## Operation
- Reset values: state IDLE, soft_rst_n=3'b111, busy=0, done=0, timeout_err=0, counter=0, latched sel=0, synchronizers=0.
- IDLE
  - On sw_rst_req=1 with test_mode=0: latch sel.
  - If sel!=0, go to ASSERT, clear the counter, and drive soft_rst_n[i]=0 for every selected i.
  - If sel==0, go to DONE; soft_rst_n is untouched.
- ASSERT
  - Counter increments each cycle.
  - When all selected synchronized acks are 1, go to HOLD and clear the counter.
  - If the counter reaches ACK_TIMEOUT first, set timeout_err, drive soft_rst_n=3'b111, go to DONE.
- HOLD: counter increments. When it reaches STRETCH_CYCLES-1, drive soft_rst_n=3'b111, go to RELEASE, clear the counter.
- RELEASE
  - When all selected synchronized acks are 0, go to DONE.
  - If the counter reaches ACK_TIMEOUT first, set timeout_err and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Unselected domains: never driven low and their acks are ignored.
- sw_rst_req while busy=1: ignored and not queued.
- timeout_err
  - err_clr clears it.
  - If err_clr and a new timeout occur in the same cycle, set wins.
- test_mode=1
  - soft_rst_n is forced to 3'b111 combinationally after the register (scan-safe).
  - Requests are ignored.
  - An active sequence aborts to IDLE on the next edge; no done pulse, timeout_err unchanged.
- Counter is 8 bits and saturates; it never wraps.
- prst_n asserted mid-sequence returns the block to reset values immediately (asynchronously).

## Timing
- Cycle numbering: sw_rst_req is sampled high at edge 0.
  - Edge 1: busy=1 and soft_rst_n low.
  - For sel==0, done is high after edge 1 and busy is low again after edge 2.
- Ack latency: a domain ack change is seen by the FSM SYNC_STAGES edges after it is stable at pclk.
- Minimum total duration with ideal acks: 1 (ASSERT entry) + SYNC_STAGES + STRETCH_CYCLES + SYNC_STAGES + 1 (DONE) cycles.
- done and busy are registered.
- Only the test_mode force on soft_rst_n is combinational.

## Structure
- Package soft_rst_pkg:
  - state enum: IDLE, ASSERT, HOLD, RELEASE, DONE.
  - NUM_DOM=3.
  - Domain indices DOM_SDRAM=0, DOM_SYS=1, DOM_SYS2X=2.
  - CNT_W=8.
- Sub-module sync_bit: SYNC_STAGES-deep synchronizer with asynchronous clear on prst_n, instantiated once per rst_ack bit.
- Top level holds the FSM, counter, sel latch, and error flag.

## Test plan
- Nominal sequence:
  - Stimulus: sel=3'b011 with an ack model that echoes soft_rst_n inverted after 3 cycles; defaults.
  - Response: soft_rst_n=3'b100 from edge 1; bit2 is never low; single done pulse; timeout_err=0.
  - Hold duration: soft_rst_n stays low exactly 16 cycles after both synchronized acks are seen.
- ASSERT timeout:
  - Stimulus: sel=3'b100 with rst_ack stuck 0.
  - Response: after 255 cycles in ASSERT, timeout_err=1, soft_rst_n=3'b111, done pulses once.
  - Clear: err_clr clears timeout_err the next cycle.
- Request while busy and zero-select:
  - Stimulus: a second sw_rst_req mid-HOLD.
  - Response: ignored; exactly one done pulse.
  - Stimulus: a request with sel=0.
  - Response: done one cycle later; soft_rst_n stays 3'b111.
- test_mode abort:
  - Stimulus: test_mode=1 during HOLD.
  - Response: soft_rst_n=3'b111 in the same cycle; busy=0 next edge; no done pulse.
- Async reset mid-sequence:
  - Stimulus: prst_n low during ASSERT.
  - Response: all outputs return to reset values without waiting for a pclk edge.
  - Stimulus: a new request after prst_n deasserts.
  - Response: a normal sequence.
- RELEASE timeout:
  - Stimulus: rst_ack stuck 1 after HOLD.
  - Response: timeout_err=1 after 255 RELEASE cycles; soft_rst_n remains 3'b111.
